// File: rtl/arm_pkg.sv
// Shared types and defaults for the ARM pipeline memory-side blocks.
// Holds the SRAM controller FSM encoding and its parameter defaults.
package arm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow  = 2'd1,
        StHigh = 2'd2,
        StDone = 2'd3
    } sram_state_e;

    localparam int unsigned SramAccessCyclesDefault = 3;
    localparam int unsigned SramDataBaseDefault     = 1024;

endpackage

// File: rtl/sram_controller.sv
// 32-bit load/store port onto a 16-bit asynchronous SRAM: each word is moved
// as two half-word phases (low then high), stalling the pipeline meanwhile.
module sram_controller
    import arm_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = SramAccessCyclesDefault,
    parameter int unsigned DATA_BASE     = SramDataBaseDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  logic [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : g_param_check
        $error("ACCESS_CYCLES must lie in 2..15");
    end

    localparam logic [3:0] CntLast = 4'(ACCESS_CYCLES - 1);

    sram_state_e r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_is_write, w_is_write_next;
    logic [31:0] r_wdata, w_wdata_next;
    logic [31:0] r_read_data, w_read_data_next;
    logic [17:0] r_sram_addr, w_sram_addr_next;

    logic        w_req;
    logic        w_last;
    logic        w_ready;
    logic        w_we_n;
    logic        w_dq_oe;
    logic [15:0] w_dq_out;
    logic [31:0] w_offset;
    logic        w_unused_offset;

    // Offset wraps modulo 2^32; only the word index bits select SRAM storage.
    assign w_offset        = address - 32'(DATA_BASE);
    assign w_unused_offset = ^{w_offset[31:19], w_offset[1:0]};
    assign w_req           = wr_en | rd_en;
    assign w_last          = (r_cnt == CntLast);

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_is_write_next  = r_is_write;
        w_wdata_next     = r_wdata;
        w_read_data_next = r_read_data;
        w_sram_addr_next = r_sram_addr;
        w_ready          = 1'b0;
        w_we_n           = 1'b1;
        w_dq_oe          = 1'b0;
        w_dq_out         = r_wdata[15:0];

        case (r_state)
            StIdle: begin
                w_ready = !w_req;
                if (w_req) begin
                    // A simultaneous rd_en is ignored: write takes priority.
                    w_is_write_next  = wr_en;
                    w_wdata_next     = write_data;
                    w_sram_addr_next = {w_offset[18:2], 1'b0};
                    w_cnt_next       = 4'd0;
                    w_state_next     = StLow;
                end
            end
            StLow: begin
                w_dq_oe  = r_is_write;
                w_dq_out = r_wdata[15:0];
                // WE_N rises on the final cycle so data is held past the write strobe.
                w_we_n   = !(r_is_write && !w_last);
                if (w_last) begin
                    if (!r_is_write) begin
                        w_read_data_next[15:0] = SRAM_DQ;
                    end
                    w_sram_addr_next = {r_sram_addr[17:1], 1'b1};
                    w_cnt_next       = 4'd0;
                    w_state_next     = StHigh;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            StHigh: begin
                w_dq_oe  = r_is_write;
                w_dq_out = r_wdata[31:16];
                w_we_n   = !(r_is_write && !w_last);
                if (w_last) begin
                    if (!r_is_write) begin
                        w_read_data_next[31:16] = SRAM_DQ;
                    end
                    w_cnt_next   = 4'd0;
                    w_state_next = StDone;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            StDone: begin
                w_ready      = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_is_write  <= 1'b0;
            r_wdata     <= 32'd0;
            r_read_data <= 32'd0;
            r_sram_addr <= 18'd0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_is_write  <= w_is_write_next;
            r_wdata     <= w_wdata_next;
            r_read_data <= w_read_data_next;
            r_sram_addr <= w_sram_addr_next;
        end
    end

    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'hzzzz;
    assign SRAM_WE_N = w_we_n;
    assign SRAM_ADDR = r_sram_addr;
    assign ready     = w_ready;
    assign read_data = r_read_data;

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 3: cycles per 16-bit SRAM half-access; legal values 2..15.
REQ-002 SHALL have parameter DATA_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write request, level, from the MEM stage.
- rd_en  in  1  read request, level, from the MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  loaded word.
- ready  out  1  high = no stall; drives pipeline freeze_N.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_WE_N  out  1  SRAM write enable, active-low.

Function
REQ-005 SHALL compute offset = (address - DATA_BASE) mod 2^32 and word index = offset[18:2]; low half at SRAM_ADDR {index,0}, high half at {index,1}; bits [1:0] and [31:19] of offset are ignored.
REQ-006 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-007 IDLE: if wr_en or rd_en is high, SHALL latch the operation, address and write_data, then go to LOW; otherwise stay in IDLE.
REQ-008 SHALL treat wr_en and rd_en both high as a write.
REQ-009 LOW and HIGH SHALL each last exactly ACCESS_CYCLES cycles, counted by an internal counter that resets to 0 on every phase entry.
- LOW ends by going to HIGH.
- HIGH ends by going to DONE.
REQ-010 DONE SHALL last one cycle, then go to IDLE.
REQ-011 SHALL drive ready = (IDLE and no request) or DONE, combinationally; a request therefore holds ready low for 2*ACCESS_CYCLES+1 cycles.
REQ-012 Write, LOW/HIGH phases: SHALL drive SRAM_DQ with write_data[15:0] / [31:16] for the whole phase.
REQ-013 Write, LOW/HIGH phases: SHALL hold SRAM_WE_N low for the first ACCESS_CYCLES-1 cycles of the phase and high on its last cycle.
REQ-014 Read: SHALL keep SRAM_WE_N high and SRAM_DQ at high-Z.
- Capture SRAM_DQ into read_data[15:0] on the last LOW cycle.
- Capture SRAM_DQ into read_data[31:16] on the last HIGH cycle.
REQ-015 read_data SHALL hold its value until the next read completes and SHALL be valid in DONE.
REQ-016 A request dropped or changed mid-operation SHALL NOT alter the latched operation, which runs to completion.
REQ-017 In IDLE and DONE: SRAM_WE_N high, SRAM_DQ high-Z, SRAM_ADDR holds its last value.

Reset
REQ-018 On rst, SHALL enter IDLE and clear the counter, read_data and SRAM_ADDR to 0.
REQ-019 On rst, SHALL set SRAM_WE_N to 1 and release SRAM_DQ to high-Z.
REQ-020 rst asserted during LOW or HIGH SHALL abort the access within the same edge, and ready SHALL follow REQ-011 on the next cycle.

Structure
REQ-021 The FSM state enum, the DATA_BASE default and the ACCESS_CYCLES default SHALL live in the shared arm_pkg package.
REQ-022 SHALL be a single module with no sub-module; the tri-state driver is inline.

Verification
REQ-023 Idle: rd_en=wr_en=0 for 5 cycles -> ready=1, SRAM_WE_N=1, SRAM_DQ high-Z throughout.
REQ-024 Write: wr_en, address=1028, write_data=0xDEADBEEF -> SRAM half-word 2 = 0xBEEF, half-word 3 = 0xDEAD.
- SRAM_WE_N low for 2 cycles per half.
- ready low for exactly 7 cycles.
REQ-025 Read back: rd_en, address=1028, SRAM model preloaded as in REQ-024 -> read_data=0xDEADBEEF in DONE; ready low 7 cycles; read_data still 0xDEADBEEF 10 cycles later.
REQ-026 Both enables: wr_en=rd_en=1, address=1024, write_data=0x12345678 -> write occurs (half-word 0 = 0x5678, half-word 1 = 0x1234); read_data unchanged.
REQ-027 Reset mid-operation: rst pulsed in the 2nd LOW cycle of a write -> next cycle SRAM_WE_N=1, SRAM_DQ high-Z, state IDLE; half-word 1 not written.
REQ-028 Back-to-back: read of 1024 immediately followed by read of 1032 -> both complete, ready high for exactly one DONE cycle between them, total 15 cycles.
